// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with first-word-fall-through output. Optionally holds each
// packet until its tlast word is stored, falling back to cut-through when a packet cannot fit.
module axis_pkt_fifo #(
    parameter int data_width = 16,
    parameter int size       = 2048,
    parameter bit pkt_mode   = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [data_width-1:0]   data_in,
    input  logic                    tvalid_in,
    input  logic                    tlast_in,
    output logic                    tready_out,
    output logic [data_width-1:0]   data_out,
    output logic                    tvalid_out,
    output logic                    tlast_out,
    input  logic                    tready_in,
    output logic [$clog2(size):0]   level,
    output logic [$clog2(size):0]   pkt_level,
    output logic                    oversize
);

    localparam int aw = $clog2(size);
    localparam logic [aw:0] full_level = {1'b1, {aw{1'b0}}};
    localparam logic [aw:0] one        = {{aw{1'b0}}, 1'b1};

    typedef enum logic {
        st_normal,
        st_oversize
    } state_t;

    state_t state, state_next;

    logic [data_width:0] mem [size];
    logic [aw:0]         wr_ptr, rd_ptr;
    logic                wr_en, rd_en;

    // Pointers carry one extra wrap bit, so the difference spans 0..size.
    assign level      = wr_ptr - rd_ptr;
    assign tready_out = !reset && (level != full_level);
    assign wr_en      = tvalid_in && tready_out;
    assign rd_en      = tvalid_out && tready_in;
    assign {tlast_out, data_out} = mem[rd_ptr[aw-1:0]];

    // While in oversize the consumer may catch up with the producer; valid is
    // then gated by level so an empty FIFO never presents a stale word.
    assign tvalid_out = pkt_mode ? ((pkt_level != '0) || (state == st_oversize && level != '0))
                                 : (level != '0);

    // NOTE: the storage array has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[aw-1:0]] <= {tlast_in, data_in};
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_level <= '0;
            state     <= st_normal;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + one;
            if (rd_en) rd_ptr <= rd_ptr + one;
            case ({wr_en && tlast_in, rd_en && tlast_out})
                2'b10:   pkt_level <= pkt_level + one;
                2'b01:   pkt_level <= pkt_level - one;
                default: ;
            endcase
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults come first so no path through the case infers a latch.
        state_next = state;
        oversize   = 1'b0;
        case (state)
            st_normal: begin
                if (pkt_mode && level == full_level && pkt_level == '0) begin
                    state_next = st_oversize;
                    oversize   = 1'b1;
                end
            end
            st_oversize: begin
                if (rd_en && tlast_out) state_next = st_normal;
            end
            default: state_next = st_normal;
        endcase
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one cut-through and one store-and-forward instance,
// both size 8, compared against a queue-based packet model.
module tb_axis_pkt_fifo;

    localparam int dw    = 16;
    localparam int depth = 8;
    localparam int lw    = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [dw-1:0] din  [2];
    logic          vin  [2];
    logic          lin  [2];
    logic          rin  [2];
    logic          rout [2];
    logic [dw-1:0] dout [2];
    logic          vout [2];
    logic          lout [2];
    logic          ovs  [2];
    logic [lw-1:0] lvl  [2];
    logic [lw-1:0] plvl [2];

    always #5 clk = ~clk;

    axis_pkt_fifo #(.data_width(dw), .size(depth), .pkt_mode(1'b0)) dut_ct (
        .clk(clk), .reset(reset),
        .data_in(din[0]), .tvalid_in(vin[0]), .tlast_in(lin[0]), .tready_out(rout[0]),
        .data_out(dout[0]), .tvalid_out(vout[0]), .tlast_out(lout[0]), .tready_in(rin[0]),
        .level(lvl[0]), .pkt_level(plvl[0]), .oversize(ovs[0])
    );

    axis_pkt_fifo #(.data_width(dw), .size(depth), .pkt_mode(1'b1)) dut_sf (
        .clk(clk), .reset(reset),
        .data_in(din[1]), .tvalid_in(vin[1]), .tlast_in(lin[1]), .tready_out(rout[1]),
        .data_out(dout[1]), .tvalid_out(vout[1]), .tlast_out(lout[1]), .tready_in(rin[1]),
        .level(lvl[1]), .pkt_level(plvl[1]), .oversize(ovs[1])
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: stored words in order, complete-packet count, fallback flag.
    int          sel = 0;
    logic [16:0] mq[$];
    int          m_pkts  = 0;
    bit          m_os    = 1'b0;
    int          n_reads = 0;
    bit          last_acc;

    function automatic bit exp_ready();
        return mq.size() != depth;
    endfunction

    function automatic bit exp_valid();
        if (sel == 0) return mq.size() != 0;
        return (m_pkts != 0) || (m_os && mq.size() != 0);
    endfunction

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            din[i] = '0; vin[i] = 1'b0; lin[i] = 1'b0; rin[i] = 1'b0;
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_pkts  = 0;
        m_os    = 1'b0;
        n_reads = 0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
    endtask

    // One clock: compare every observable against the model, then advance both.
    task automatic cycle(input logic v, input logic [15:0] d, input logic l, input logic r);
        bit e_rdy, e_vld, e_ovs, wr, rd;
        e_rdy = exp_ready();
        e_vld = exp_valid();
        e_ovs = (sel == 1) && (mq.size() == depth) && (m_pkts == 0) && !m_os;
        din[sel] = d; vin[sel] = v; lin[sel] = l; rin[sel] = r;
        #1;
        tests_run++;
        if (rout[sel] !== e_rdy) begin
            tests_failed++;
            $display("FAIL ready m%0d: got %b expected %b", sel, rout[sel], e_rdy);
        end
        tests_run++;
        if (vout[sel] !== e_vld) begin
            tests_failed++;
            $display("FAIL valid m%0d: got %b expected %b", sel, vout[sel], e_vld);
        end
        tests_run++;
        if (lvl[sel] !== lw'(mq.size())) begin
            tests_failed++;
            $display("FAIL level m%0d: got %0d expected %0d", sel, lvl[sel], mq.size());
        end
        tests_run++;
        if (plvl[sel] !== lw'(m_pkts)) begin
            tests_failed++;
            $display("FAIL pkt_level m%0d: got %0d expected %0d", sel, plvl[sel], m_pkts);
        end
        tests_run++;
        if (ovs[sel] !== e_ovs) begin
            tests_failed++;
            $display("FAIL oversize m%0d: got %b expected %b", sel, ovs[sel], e_ovs);
        end
        if (e_vld) begin
            tests_run++;
            if ({lout[sel], dout[sel]} !== mq[0]) begin
                tests_failed++;
                $display("FAIL data m%0d: got %h expected %h", sel, {lout[sel], dout[sel]}, mq[0]);
            end
        end
        wr = v && e_rdy;
        rd = e_vld && r;
        last_acc = wr;
        @(posedge clk); #1;
        if (rd) begin
            if (mq[0][16]) begin
                m_pkts--;
                m_os = 1'b0;
            end
            void'(mq.pop_front());
            n_reads++;
        end
        if (wr) begin
            mq.push_back({l, d});
            if (l) m_pkts++;
        end
        if (e_ovs) m_os = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_valid() && n < budget) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        tests_run++;
        if (exp_valid()) begin
            tests_failed++;
            $display("FAIL drain_timeout m%0d: got %0d words left expected 0", sel, mq.size());
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 reset = 1'b1;
        #1;
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if ({rout[m], vout[m], ovs[m], lvl[m], plvl[m]} !== '0) begin
                tests_failed++;
                $display("FAIL reset_state m%0d: got rdy=%b vld=%b ovs=%b lvl=%0d plvl=%0d expected all 0",
                         m, rout[m], vout[m], ovs[m], lvl[m], plvl[m]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        @(posedge clk); #1;
        for (int m = 0; m < 2; m++) begin
            tests_run++;
            if (rout[m] !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_release_ready m%0d: got %b expected 1", m, rout[m]);
            end
        end
    endtask

    task automatic test_cut_through();
        int peak = 0;
        sel = 0;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 16'(i + 1), i == 4, 1'b1);
            if (i == 0) begin
                tests_run++;
                if (vout[0] !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL ct_first_valid: got %b expected 1", vout[0]);
                end
            end
            if (int'(lvl[0]) > peak) peak = int'(lvl[0]);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b0, 1'b1);
            if (int'(lvl[0]) > peak) peak = int'(lvl[0]);
        end
        tests_run++;
        if (peak != 1 || n_reads != 5) begin
            tests_failed++;
            $display("FAIL ct_peak_reads: got peak=%0d reads=%0d expected peak=1 reads=5", peak, n_reads);
        end
    endtask

    task automatic test_full();
        int acc = 0;
        sel = 0;
        apply_reset();
        for (int cyc = 0; cyc < 40 && acc < 10; cyc++) begin
            cycle(1'b1, 16'h0100 + 16'(acc), acc == 9, cyc >= 15);
            if (last_acc) acc++;
            if (cyc == 13) begin
                tests_run++;
                if (acc != 8 || lvl[0] !== 4'd8 || rout[0] !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL full_block: got acc=%0d lvl=%0d rdy=%b expected 8 8 0", acc, lvl[0], rout[0]);
                end
            end
        end
        drain(20);
        tests_run++;
        if (acc != 10 || n_reads != 10) begin
            tests_failed++;
            $display("FAIL full_all_out: got acc=%0d reads=%0d expected 10 10", acc, n_reads);
        end
    endtask

    task automatic test_store_forward();
        sel = 1;
        apply_reset();
        for (int w = 0; w < 3; w++) begin
            cycle(1'b1, 16'h00A0 + 16'(w), w == 2, 1'b1);
            if (w < 2) begin
                for (int g = 0; g < 2; g++) begin
                    cycle(1'b0, '0, 1'b0, 1'b1);
                    tests_run++;
                    if (vout[1] !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL sf_gated: got %b expected 0", vout[1]);
                    end
                end
            end
        end
        tests_run++;
        if (vout[1] !== 1'b1 || plvl[1] !== 4'd1) begin
            tests_failed++;
            $display("FAIL sf_release: got vld=%b plvl=%0d expected 1 1", vout[1], plvl[1]);
        end
        drain(10);
        tests_run++;
        if (n_reads != 3) begin
            tests_failed++;
            $display("FAIL sf_reads: got %0d expected 3", n_reads);
        end
    endtask

    task automatic test_simul_tlast();
        sel = 1;
        apply_reset();
        cycle(1'b1, 16'h00B0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00B1, 1'b1, 1'b0);
        cycle(1'b1, 16'h00C0, 1'b0, 1'b1);
        cycle(1'b1, 16'h00C1, 1'b1, 1'b1);
        tests_run++;
        if (plvl[1] !== 4'd1 || lvl[1] !== 4'd2) begin
            tests_failed++;
            $display("FAIL simul_tlast: got plvl=%0d lvl=%0d expected 1 2", plvl[1], lvl[1]);
        end
        drain(10);
    endtask

    task automatic test_oversize();
        int acc = 0;
        int pulses = 0;
        sel = 1;
        apply_reset();
        for (int cyc = 0; cyc < 60 && acc < 12; cyc++) begin
            if (ovs[1] === 1'b1) begin
                pulses++;
                tests_run++;
                if (lvl[1] !== 4'd8) begin
                    tests_failed++;
                    $display("FAIL os_level: got %0d expected 8", lvl[1]);
                end
            end
            cycle(1'b1, 16'hC000 + 16'(acc), acc == 11, 1'b1);
            if (last_acc) acc++;
        end
        for (int n = 0; n < 20 && exp_valid(); n++) begin
            if (ovs[1] === 1'b1) pulses++;
            cycle(1'b0, '0, 1'b0, 1'b1);
        end
        tests_run++;
        if (pulses != 1 || acc != 12 || n_reads != 12) begin
            tests_failed++;
            $display("FAIL os_stream: got pulses=%0d acc=%0d reads=%0d expected 1 12 12", pulses, acc, n_reads);
        end
        cycle(1'b1, 16'h00D0, 1'b0, 1'b1);
        cycle(1'b1, 16'h00D1, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        tests_run++;
        if (vout[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL os_cleared: got vld=%b expected 0", vout[1]);
        end
        cycle(1'b1, 16'h00D2, 1'b1, 1'b1);
        drain(10);
    endtask

    task automatic test_reset_mid();
        sel = 1;
        apply_reset();
        cycle(1'b1, 16'h00E0, 1'b0, 1'b0);
        cycle(1'b1, 16'h00E1, 1'b1, 1'b0);
        for (int i = 2; i < 5; i++) cycle(1'b1, 16'h00E0 + 16'(i), 1'b0, 1'b0);
        tests_run++;
        if (lvl[1] !== 4'd5 || plvl[1] !== 4'd1) begin
            tests_failed++;
            $display("FAIL mid_fill: got lvl=%0d plvl=%0d expected 5 1", lvl[1], plvl[1]);
        end
        clear_inputs();
        #2 reset = 1'b1;
        #1;
        tests_run++;
        if (lvl[1] !== 4'd0 || plvl[1] !== 4'd0 || vout[1] !== 1'b0 || rout[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_async_reset: got lvl=%0d plvl=%0d vld=%b rdy=%b expected 0 0 0 0",
                     lvl[1], plvl[1], vout[1], rout[1]);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        @(posedge clk); #1;
        tests_run++;
        if (rout[1] !== 1'b1 || vout[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_release: got rdy=%b vld=%b expected 1 0", rout[1], vout[1]);
        end
        cycle(1'b1, 16'h00F0, 1'b1, 1'b0);
        drain(5);
    endtask

    task automatic test_random();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            apply_reset();
            for (int i = 0; i < 600; i++) begin
                // Alternate between slow and fast consumers to reach full and empty.
                logic r;
                r = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
                cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 4) == 0, r);
            end
            drain(40);
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_cut_through();
        test_full();
        test_store_forward();
        test_simul_tlast();
        test_oversize();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/axis_pkt_fifo.md
AXIS_PKT_FIFO -- requirements
Module: axis_pkt_fifo

Interface
REQ-001 SHALL have parameter data_width, default 16: width of data_in/data_out.
REQ-002 SHALL have parameter size, default 2048: entries; power of two, >= 4.
REQ-003 SHALL have parameter pkt_mode, default 0: 0 = cut-through, 1 = store-and-forward per packet.
REQ-004 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port data_in  in  data_width  upstream AXI-Stream data.
REQ-007 SHALL have port tvalid_in  in  1  upstream valid.
REQ-008 SHALL have port tlast_in  in  1  upstream end-of-packet.
REQ-009 SHALL have port tready_out  out  1  ready to upstream.
REQ-010 SHALL have port data_out  out  data_width  downstream data.
REQ-011 SHALL have port tvalid_out  out  1  downstream valid.
REQ-012 SHALL have port tlast_out  out  1  downstream end-of-packet.
REQ-013 SHALL have port tready_in  in  1  downstream ready.
REQ-014 SHALL have port level  out  log2(size)+1  stored word count, 0..size.
REQ-015 SHALL have port pkt_level  out  log2(size)+1  complete packets stored.
REQ-016 SHALL have port oversize  out  1  one-cycle pulse on oversize-fallback entry.

Function
REQ-017 SHALL store {tlast_in, data_in} per entry; write on tvalid_in && tready_out; read on tvalid_out && tready_in.
REQ-018 SHALL use write/read pointers of log2(size)+1 bits, wrapping modulo 2*size; level = wr_ptr - rd_ptr.
REQ-019 SHALL drive tready_out = (level != size); full blocks writes even if a read occurs the same cycle (no bypass).
REQ-020 SHALL be first-word-fall-through: data_out/tlast_out = entry at rd_ptr, valid whenever tvalid_out = 1.
REQ-021 SHALL, with pkt_mode = 0, drive tvalid_out = (level != 0); word written at edge N is presented from cycle N+1.
REQ-022 SHALL increment pkt_level on accepted write with tlast_in = 1, decrement on accepted read with tlast_out = 1, and hold it when both occur together.
REQ-023 SHALL, with pkt_mode = 1, drive tvalid_out = (pkt_level != 0) || oversize_state; tvalid_out rises the cycle after the tlast word is written.
REQ-024 SHALL enter oversize_state when pkt_mode = 1, level = size and pkt_level = 0, pulse oversize for that one cycle, and present words cut-through.
REQ-025 SHALL leave oversize_state on the accepted read of a word with tlast_out = 1.
REQ-026 SHALL hold data_out, tlast_out and tvalid_out stable while tvalid_out && !tready_in (AXI-Stream rule).
REQ-027 SHALL hold level when a write and a read are accepted in the same cycle.
REQ-028 SHALL treat data_out/tlast_out as don't-care while tvalid_out = 0.

Reset
REQ-029 SHALL, while reset = 1, force pointers, level, pkt_level and oversize_state to 0, tvalid_out = 0, tready_out = 0 and oversize = 0.
REQ-030 SHALL drive tready_out = 1 in the first cycle after reset deasserts.
REQ-031 SHALL not reset the storage array; reset mid-packet discards all stored and partial packets.

Verification
REQ-032 SHALL pass: size=8, pkt_mode=0, tready_in=1, write 0x0001..0x0005 back-to-back -> same order out, first tvalid_out one cycle after first write, level peaks at 1.
REQ-033 SHALL pass: size=8, pkt_mode=0, tready_in=0, write 10 words -> tready_out=0 after 8th accept, level=8, words 9-10 held; tready_in=1 then yields all 10 in order.
REQ-034 SHALL pass: size=8, pkt_mode=1, 3-word packet 0xA0..0xA2 (tlast on 0xA2) with 2-cycle gaps -> tvalid_out=0 until cycle after 0xA2 write, pkt_level=1, then 0xA0..0xA2 out with tlast_out on 0xA2.
REQ-035 SHALL pass: size=8, pkt_mode=1, simultaneous tlast write and tlast read -> pkt_level unchanged.
REQ-036 SHALL pass: size=8, pkt_mode=1, 12-word packet with no early tlast -> oversize pulses once at level=8, words stream out, oversize_state clears on tlast read.
REQ-037 SHALL pass: reset asserted mid-packet at level=5 -> level=0, pkt_level=0, tvalid_out=0 immediately (asynchronous), tready_out=1 the cycle after deassertion.
